hash_job_memory: RTL and testbench
==================================

HASH_JOB_MEMORY -- requirements
Module: hash_job_memory

Interface
REQ-001 Parameter MSG_BASE, 16'h0000, word address of the 19-word message region.
REQ-002 Parameter OUT_BASE, 16'h0020, word address of the 16-word result region.
REQ-003 Parameter DEPTH, 64, number of 32-bit storage words, addresses 0..DEPTH-1.
REQ-004 Parameter TIMEOUT, 4096, maximum number of cycles to wait for hasher done.
REQ-005 Port clk, input, 1, the only clock; it also clocks the hasher memory port.
REQ-006 Port reset_n, input, 1, asynchronous active-low reset.
REQ-007 Port in_valid / in_ready / in_data, input / output / input, 1/1/32, host message-word stream.
REQ-008 Port out_valid / out_ready / out_data / out_last, output / input / output / output, 1/1/32/1, host result stream.
REQ-009 Port start, output, 1, one-cycle start pulse to the hasher.
REQ-010 Port done, input, 1, hasher completion level.
REQ-011 Port message_addr / output_addr, output, 16 each, constant MSG_BASE / OUT_BASE.
REQ-012 Port mem_we / mem_addr / mem_write_data, input, 1/16/32, hasher memory requests.
REQ-013 Port mem_read_data, output, 32, registered read data.
REQ-014 Port busy / err, output, 1 each; busy = state not IDLE; err = sticky error flag.

Function
REQ-015 States SHALL be IDLE, LOAD, KICK, WAIT and DRAIN.
REQ-016 IDLE SHALL go to LOAD on the first cycle in_valid=1; that cycle SHALL also clear err.
REQ-017 LOAD SHALL hold in_ready=1 and, on each in_valid&&in_ready cycle, write in_data to MSG_BASE+k (k=0..18).
REQ-018 LOAD SHALL go to KICK after the 19th accepted word.
REQ-019 KICK SHALL last exactly 1 cycle with start=1, then go to WAIT.
REQ-020 WAIT SHALL go to DRAIN on the first cycle done=1.
REQ-021 If done stays 0 for TIMEOUT cycles in WAIT, the block SHALL set err and go to IDLE, and SHALL NOT stream any results.
REQ-022 Hasher read: mem_read_data SHALL equal mem[mem_addr] sampled at the previous clk edge (1-cycle latency); this SHALL hold in every state.
REQ-023 Hasher read out of range: if mem_addr >= DEPTH, the next cycle's mem_read_data SHALL be 0 and err SHALL be set.
REQ-024 Hasher write: mem_we=1 in WAIT SHALL write mem_write_data to mem_addr at the clock edge; a read of the same address on the next cycle SHALL return the new data.
REQ-025 mem_we=1 outside WAIT, or with mem_addr >= DEPTH, SHALL be ignored and SHALL set err.
REQ-026 DRAIN SHALL hold out_valid=1 with out_data=mem[OUT_BASE+j], j=0..15, advancing j only on out_valid&&out_ready.
REQ-027 out_data SHALL stay stable while stalled; out_last=1 only when j=15.
REQ-028 The handshake with j=15 SHALL return the block to IDLE.
REQ-029 in_ready SHALL be 0 outside LOAD; out_valid SHALL be 0 outside DRAIN.
REQ-030 An in_valid arriving during KICK, WAIT or DRAIN SHALL be back-pressured, not dropped.
REQ-031 Word and result counters SHALL be 5-bit and the timeout counter SHALL saturate; none SHALL wrap.

Reset
REQ-032 Asynchronous assertion of reset_n=0 SHALL immediately force: state IDLE, counters 0, start 0, in_ready 0, out_valid 0, out_last 0, out_data 0, mem_read_data 0, err 0, busy 0.
REQ-033 Storage array contents SHALL NOT be reset.
REQ-034 A reset asserted mid-LOAD or mid-DRAIN SHALL abandon the job, and the next job SHALL restart at word 0.

Structure
REQ-035 The state enum and the default MSG_BASE, OUT_BASE, NUM_WORDS=19, NUM_NONCE=16 and TIMEOUT values SHALL live in shared package hash_pkg.
REQ-036 Storage SHALL be one sub-module, hash_word_ram (1 write port, 2 registered/combinational read ports: hasher and drain).

Verification
REQ-037 Load words 32'h00000000..32'h00000012, hasher model writes 32'hA0000000+j to 32+j when done -> start pulses 1 cycle after the 19th word; out_data 32'hA0000000..32'hA000000F; out_last on the 16th.
REQ-038 Hasher reads addr 5 then 6 in consecutive cycles -> mem_read_data 32'h5 then 32'h6, each one cycle later.
REQ-039 out_ready low for 3 cycles at j=7 -> out_data holds 32'hA0000007 for those cycles and no word is skipped.
REQ-040 done never asserted -> err=1 and busy=0 after 4096 WAIT cycles; out_valid never 1.
REQ-041 mem_we=1 at addr 16'h0040 in WAIT -> no write, err=1; next job start clears err.
REQ-042 reset_n pulsed low after 10 loaded words -> all outputs are reset values; a fresh 19-word load completes normally.

Source files
------------

// File: rtl/hash_pkg.sv
// Shared types and default geometry for the hash job memory block.
package hash_pkg;
  localparam logic [15:0] MSG_BASE_DEF = 16'h0000;
  localparam logic [15:0] OUT_BASE_DEF = 16'h0020;
  localparam int          DEPTH_DEF    = 64;
  localparam int          NUM_WORDS    = 19;
  localparam int          NUM_NONCE    = 16;
  localparam int          TIMEOUT_DEF  = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KICK,
    ST_WAIT,
    ST_DRAIN
  } state_e;

  function automatic logic addr_in_range(input logic [15:0] addr, input int depth);
    return {16'h0000, addr} < 32'(depth);
  endfunction
endpackage

// File: rtl/hash_job_memory_if.sv
// Host message/result streams plus the hasher control and memory port.
interface hash_job_memory_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        start;
  logic        done;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        busy;
  logic        err;

  modport slave (
    input  in_valid, in_data, out_ready, done, mem_we, mem_addr, mem_write_data,
    output in_ready, out_valid, out_data, out_last, start, message_addr, output_addr,
           mem_read_data, busy, err
  );

  modport master (
    output in_valid, in_data, out_ready, done, mem_we, mem_addr, mem_write_data,
    input  in_ready, out_valid, out_data, out_last, start, message_addr, output_addr,
           mem_read_data, busy, err
  );
endinterface

// File: rtl/hash_word_ram.sv
// Word store: one write port, a registered hasher read port and a combinational drain port.
module hash_word_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o,
  input  logic [AW-1:0] draddr_i,
  output logic [31:0]   drdata_o
);
  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Out-of-range hasher reads return zero rather than an aliased word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rd_en_i ? mem_q[raddr_i] : '0;
    end
  end

  assign rdata_o  = rdata_q;
  assign drdata_o = mem_q[draddr_i];
endmodule

// File: rtl/hash_job_memory.sv
// Stages a 19-word message for the hasher, launches it, then streams the 16 result words.
module hash_job_memory
  import hash_pkg::*;
#(
  parameter logic [15:0] MSG_BASE = MSG_BASE_DEF,
  parameter logic [15:0] OUT_BASE = OUT_BASE_DEF,
  parameter int          DEPTH    = DEPTH_DEF,
  parameter int          TIMEOUT  = TIMEOUT_DEF
) (
  input logic              clk,
  input logic              reset_n,
  hash_job_memory_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e        state_q;
  logic [4:0]    word_cnt_q;
  logic [4:0]    res_cnt_q;
  logic [TW-1:0] wait_cnt_q;
  logic          start_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic          err_q;
  logic          err_d;

  logic          addr_ok;
  logic          load_fire;
  logic          hash_wr_ok;
  logic          timeout_hit;
  logic          job_open;
  logic          err_set;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [31:0]   rd_data;
  logic [31:0]   drain_data;

  assign addr_ok     = addr_in_range(bus.mem_addr, DEPTH);
  assign load_fire   = in_ready_q && bus.in_valid;
  assign hash_wr_ok  = bus.mem_we && addr_ok && (state_q == ST_WAIT);
  assign timeout_hit = (state_q == ST_WAIT) && !bus.done && (wait_cnt_q == TW'(TIMEOUT - 1));
  assign job_open    = (state_q == ST_IDLE) && bus.in_valid;
  assign err_set     = !addr_ok || (bus.mem_we && !hash_wr_ok) || timeout_hit;

  // A fresh error in the same cycle a job opens still wins.
  always_comb begin
    err_d = err_q;
    if (job_open) err_d = 1'b0;
    if (err_set)  err_d = 1'b1;
  end

  // Host loading and hasher writes live in disjoint states, so one write port suffices.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = AW'(bus.mem_addr);
    ram_wdata = bus.mem_write_data;
    if (load_fire) begin
      ram_we    = 1'b1;
      ram_waddr = AW'(MSG_BASE + 16'(word_cnt_q));
      ram_wdata = bus.in_data;
    end else if (hash_wr_ok) begin
      ram_we = 1'b1;
    end
  end

  hash_word_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk      (clk),
    .rst_n    (reset_n),
    .we_i     (ram_we),
    .waddr_i  (ram_waddr),
    .wdata_i  (ram_wdata),
    .rd_en_i  (addr_ok),
    .raddr_i  (AW'(bus.mem_addr)),
    .rdata_o  (rd_data),
    .draddr_i (AW'(OUT_BASE + 16'(res_cnt_q))),
    .drdata_o (drain_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      word_cnt_q  <= '0;
      res_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      start_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q   <= err_d;
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            state_q    <= ST_LOAD;
            in_ready_q <= 1'b1;
            word_cnt_q <= '0;
          end
        end
        ST_LOAD: begin
          if (load_fire) begin
            if (word_cnt_q == 5'(NUM_WORDS - 1)) begin
              state_q    <= ST_KICK;
              in_ready_q <= 1'b0;
              start_q    <= 1'b1;
              word_cnt_q <= '0;
            end else begin
              word_cnt_q <= word_cnt_q + 5'd1;
            end
          end
        end
        ST_KICK: begin
          state_q    <= ST_WAIT;
          wait_cnt_q <= '0;
        end
        ST_WAIT: begin
          if (bus.done) begin
            state_q     <= ST_DRAIN;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            res_cnt_q   <= '0;
          end else if (timeout_hit) begin
            state_q <= ST_IDLE;
          end else if (wait_cnt_q != '1) begin
            wait_cnt_q <= wait_cnt_q + TW'(1);
          end
        end
        ST_DRAIN: begin
          if (out_valid_q && bus.out_ready) begin
            if (res_cnt_q == 5'(NUM_NONCE - 1)) begin
              state_q     <= ST_IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              res_cnt_q   <= '0;
            end else begin
              res_cnt_q  <= res_cnt_q + 5'd1;
              out_last_q <= (res_cnt_q == 5'(NUM_NONCE - 2));
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_last      = out_last_q;
  assign bus.out_data      = out_valid_q ? drain_data : '0;
  assign bus.start         = start_q;
  assign bus.message_addr  = MSG_BASE;
  assign bus.output_addr   = OUT_BASE;
  assign bus.mem_read_data = rd_data;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.err           = err_q;
endmodule

// File: tb/tb_hash_job_memory.sv
// Self-checking bench for hash_job_memory: directed jobs, a read table and randomized jobs.
module tb_hash_job_memory;
  import hash_pkg::*;

  localparam int TO = 4096;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  hash_job_memory_if bus ();

  hash_job_memory #(
    .MSG_BASE (16'h0000),
    .OUT_BASE (16'h0020),
    .DEPTH    (64),
    .TIMEOUT  (TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic        err;
  } rd_vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] ref_mem    [64];
  logic        exp_err;
  logic [31:0] job_words  [19];
  logic [31:0] next_words [19];
  rd_vec_t     rd_tab     [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_rdata", 64'(bus.mem_read_data), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_start", 64'(bus.start), 64'd0);
    check("msg_addr", 64'(bus.message_addr), 64'h0000);
    check("out_addr", 64'(bus.output_addr), 64'h0020);
  endtask

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // A job start always clears the sticky error in the reference model.
  task automatic do_load(input int n, input bit gaps);
    exp_err = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (gaps && k > 0) repeat ($urandom_range(0, 2)) tick();
      send_word(job_words[k]);
      ref_mem[k] = job_words[k];
      if (k == 0) check("err_cleared", 64'(bus.err), 64'(exp_err));
      check("start", 64'(bus.start), 64'(k == NUM_WORDS - 1));
    end
  endtask

  task automatic hasher(input bit fixed, input bit bad_write, input bit hold_next);
    int a;
    tick();
    check("start_pulse_end", 64'(bus.start), 64'd0);
    check("wait_busy", 64'(bus.busy), 64'd1);
    for (int r = 0; r < 3; r++) begin
      a = fixed ? 5 + r : int'($urandom_range(0, NUM_WORDS - 1));
      bus.mem_addr = 16'(a);
      tick();
      check("hasher_read", 64'(bus.mem_read_data), 64'(ref_mem[a]));
    end
    if (bad_write) begin
      bus.mem_we         = 1'b1;
      bus.mem_addr       = 16'h0040;
      bus.mem_write_data = 32'hDEADBEEF;
      tick();
      bus.mem_we = 1'b0;
      exp_err    = 1'b1;
      check("bad_wr_err", 64'(bus.err), 64'(exp_err));
      check("oor_read_zero", 64'(bus.mem_read_data), 64'd0);
      bus.mem_addr = 16'h0000;
      tick();
      check("bad_wr_ignored", 64'(bus.mem_read_data), 64'(ref_mem[0]));
    end
    for (int j = 0; j < NUM_NONCE; j++) begin
      bus.mem_we         = 1'b1;
      bus.mem_addr       = 16'(32 + j);
      bus.mem_write_data = fixed ? 32'hA0000000 + 32'(j) : $urandom;
      ref_mem[32 + j]    = bus.mem_write_data;
      tick();
    end
    bus.mem_we   = 1'b0;
    bus.mem_addr = 16'h002F;
    tick();
    check("raw_read", 64'(bus.mem_read_data), 64'(ref_mem[47]));
    bus.mem_addr = 16'h0000;
    if (hold_next) begin
      bus.in_valid = 1'b1;
      bus.in_data  = next_words[0];
    end
    repeat ($urandom_range(1, 4)) begin
      tick();
      check("wait_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("drain_entry", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic drain(input bit rnd_ready, input int stall_j, input int abort_at);
    int j;
    int stall_left;
    int n;
    j          = 0;
    stall_left = 3;
    n          = 0;
    while (j < abort_at && n < 500) begin
      if (j == stall_j && stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      check("drain_word",
            64'({bus.in_ready, bus.out_valid, bus.out_last, bus.out_data}),
            64'({1'b0, 1'b1, (j == NUM_NONCE - 1), ref_mem[32 + j]}));
      tick();
      n++;
      if (bus.out_ready) j++;
    end
    bus.out_ready = 1'b0;
    check("drain_count", 64'(j), 64'(abort_at));
    if (abort_at == NUM_NONCE) begin
      check("drain_done", 64'({bus.out_valid, bus.busy}), 64'd0);
      check("err_end", 64'(bus.err), 64'(exp_err));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic saw_ov;

    bus.in_valid       = 1'b0;
    bus.in_data        = '0;
    bus.out_ready      = 1'b0;
    bus.done           = 1'b0;
    bus.mem_we         = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
    exp_err            = 1'b0;

    rd_tab[0] = '{16'd0,     32'h00000000, 1'b0};
    rd_tab[1] = '{16'd5,     32'h00000005, 1'b0};
    rd_tab[2] = '{16'd6,     32'h00000006, 1'b0};
    rd_tab[3] = '{16'd18,    32'h00000012, 1'b0};
    rd_tab[4] = '{16'd32,    32'hA0000000, 1'b0};
    rd_tab[5] = '{16'd39,    32'hA0000007, 1'b0};
    rd_tab[6] = '{16'd47,    32'hA000000F, 1'b0};
    rd_tab[7] = '{16'd64,    32'h00000000, 1'b1};
    rd_tab[8] = '{16'hFFFF,  32'h00000000, 1'b1};

    #2 reset_n = 1'b0;
    #1 check_reset_outputs();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Directed job: counting message, fixed results, stall at j=7.
    foreach (job_words[k]) job_words[k] = 32'(k);
    do_load(NUM_WORDS, 1'b0);
    hasher(1'b1, 1'b0, 1'b0);
    drain(1'b0, 7, NUM_NONCE);

    foreach (rd_tab[i]) begin
      bus.mem_addr = rd_tab[i].addr;
      tick();
      check("tab_rdata", 64'(bus.mem_read_data), 64'(rd_tab[i].data));
      check("tab_err", 64'(bus.err), 64'(rd_tab[i].err));
    end
    bus.mem_addr = 16'h0000;
    exp_err      = 1'b1;

    // Out-of-range hasher write during WAIT.
    foreach (job_words[k]) job_words[k] = $urandom;
    do_load(NUM_WORDS, 1'b1);
    hasher(1'b0, 1'b1, 1'b0);
    drain(1'b1, -1, NUM_NONCE);

    // Hasher never finishes.
    foreach (job_words[k]) job_words[k] = $urandom;
    do_load(NUM_WORDS, 1'b0);
    n      = 0;
    saw_ov = 1'b0;
    while (bus.busy && n < 6000) begin
      tick();
      n++;
      if (bus.out_valid) saw_ov = 1'b1;
    end
    exp_err = 1'b1;
    check("timeout_cycles", 64'(n), 64'(TO + 1));
    check("timeout_err", 64'(bus.err), 64'(exp_err));
    check("timeout_no_out", 64'(saw_ov), 64'd0);

    // Reset in the middle of a load.
    foreach (job_words[k]) job_words[k] = $urandom;
    do_load(10, 1'b0);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs();
    tick();
    tick();
    reset_n = 1'b1;

    // Hasher write outside WAIT is dropped and flagged.
    bus.mem_we         = 1'b1;
    bus.mem_addr       = 16'h0000;
    bus.mem_write_data = 32'h12345678;
    tick();
    bus.mem_we = 1'b0;
    exp_err    = 1'b1;
    check("idle_wr_err", 64'(bus.err), 64'(exp_err));
    tick();
    check("idle_wr_ignored", 64'(bus.mem_read_data), 64'(ref_mem[0]));

    foreach (job_words[k]) job_words[k] = $urandom;
    do_load(NUM_WORDS, 1'b1);
    hasher(1'b0, 1'b0, 1'b0);
    drain(1'b1, -1, NUM_NONCE);

    // Reset in the middle of a drain.
    foreach (job_words[k]) job_words[k] = $urandom;
    do_load(NUM_WORDS, 1'b1);
    hasher(1'b0, 1'b0, 1'b0);
    drain(1'b1, -1, 5);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs();
    tick();
    tick();
    reset_n = 1'b1;

    // Randomized jobs; the next job's first word waits on back-pressure.
    foreach (next_words[k]) next_words[k] = $urandom;
    for (int r = 0; r < 4; r++) begin
      job_words = next_words;
      foreach (next_words[k]) next_words[k] = $urandom;
      do_load(NUM_WORDS, 1'b1);
      hasher(1'b0, 1'b0, r < 3);
      drain(1'b1, -1, NUM_NONCE);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
